store_rmw: RTL and testbench
============================

# store_rmw

Store-side sub-word writer for the data memory path. It accepts a 32-bit store from the MEM stage with a width code and byte address. Word stores are written directly. Byte and halfword stores do a read-modify-write against a word-only data memory: read the word, merge the lanes, write it back. It is the write-direction counterpart of the load-path result reduction, and it stalls the pipeline while a store is in flight.

## Interface
- Parameters: none. Widths are fixed at 32 bits.
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-low reset
- StoreReq  in  1  MEM stage requests a store
- Addr  in  32  byte address of the store
- WriteData  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0])
- WidthSrc  in  3  width code from the shared package
- StoreAccept  out  1  combinational: StoreReq && state==IDLE
- StoreBusy  out  1  state != IDLE; pipeline stalls MEM and earlier stages
- StoreDone  out  1  one-cycle pulse in the cycle the memory write is issued
- MisalignedErr  out  1  one-cycle pulse: misaligned store, no write issued
- MemAddr  out  32  word address {Addr_q[31:2], 2'b00}
- MemReadEn  out  1  read request, held until MemReadValid
- MemReadData  in  32  word returned by memory
- MemReadValid  in  1  MemReadData valid this cycle
- MemWriteEn  out  1  write strobe, one cycle
- MemWriteData  out  32  full word to write

## Operation
- States: IDLE, READ, WRITE, ERROR.
- IDLE:
  - On StoreAccept, register Addr, WriteData and WidthSrc into Addr_q, Data_q and Width_q.
  - Misaligned store (halfword with Addr[0]=1, or word with Addr[1:0]!=0) -> ERROR.
  - Word store -> WRITE, with MemWriteData = Data_q.
  - Byte or halfword store -> READ.
- READ:
  - MemReadEn=1 and MemAddr driven for the whole state.
  - On MemReadValid, merge the returned word into Merge_q -> WRITE.
- WRITE:
  - MemWriteEn=1, StoreDone=1, MemWriteData = Merge_q (or Data_q for a word store) -> IDLE.
- ERROR:
  - MisalignedErr=1 for one cycle; no memory access -> IDLE.
- Merge is little-endian:
  - Byte: lane Addr_q[1:0] takes Data_q[7:0]; the other three bytes come from MemReadData.
  - Halfword: lane Addr_q[1] takes Data_q[15:0].
- Signed and unsigned width codes of the same size store identically.
- Requests made while StoreBusy=1 are not accepted. The pipeline holds StoreReq and its operands stable until StoreAccept.
- MemReadValid outside READ is ignored.
- An unused WidthSrc encoding is treated as a word store.

## Timing
- Reset (reset=0 at an edge): state=IDLE. Every output is 0 except MemAddr, which is 0 from cleared Addr_q.
- Reset mid-operation aborts the store: no write is issued, and any later MemReadValid is ignored.
- Word store: accept in cycle N; WRITE in N+1; back in IDLE at N+2. StoreBusy is high for 1 cycle.
- Sub-word store:
  - Accept in N; READ from N+1.
  - With MemReadValid in cycle N+k (k≥1), WRITE is in N+k+1 and IDLE at N+k+2.
  - With a 1-cycle memory, the store takes 3 cycles total.
- Misaligned store: accept in N; MisalignedErr in N+1; IDLE at N+2.
- Back-to-back: a new request can be accepted in the first IDLE cycle after WRITE or ERROR.
- MemWriteEn and MemReadEn are never high in the same cycle.

## Structure
- Shared package (alongside the load-path definitions) holds:
  - WidthSrc encodings: WIDTH_32=3'b000, WIDTH_16S=3'b010, WIDTH_16U=3'b110, WIDTH_8S=3'b001, WIDTH_8U=3'b101.
  - The store_state_t enum.
- Sub-module store_lane_merge: purely combinational. Inputs (OldWord, Data, ByteOffset[1:0], WidthSrc) -> MergedWord. Reused by the verification model.
- store_rmw contains the FSM, the operand registers and Merge_q.

## Test plan
- Word store: Addr=0x100, WriteData=0xDEADBEEF, WIDTH_32 -> WRITE at N+1 with MemAddr=0x100 and MemWriteData=0xDEADBEEF; MemReadEn never asserted.
- Byte store: Addr=0x203, WriteData=0x000000AB, WIDTH_8U, memory returns 0x11223344 one cycle after MemReadEn -> MemAddr=0x200, MemWriteData=0xAB223344, StoreDone at N+3.
- Halfword store: Addr=0x302, WriteData=0xFFFFCAFE, WIDTH_16S, memory returns 0x11223344 after a 3-cycle delay -> MemWriteData=0xCAFE3344; MemReadEn held for all 3 cycles.
- Misaligned store: Addr=0x401, WIDTH_16U -> MisalignedErr at N+1; MemWriteEn and MemReadEn stay 0.
- Reset mid-store: byte store accepted, reset=0 during READ, MemReadValid arrives after reset -> state IDLE, MemWriteEn never asserted, all outputs 0.
- Back-to-back: byte store, then word store held on StoreReq -> second StoreAccept in the first IDLE cycle; both writes correct and in order.

Source files
------------

// File: rtl/store_rmw_pkg.sv
// Shared definitions for the store path: width encodings, FSM states and size decode.
// The load-path reduction uses the same WidthSrc encodings.
package store_rmw_pkg;

   localparam logic [2:0] WIDTH_32  = 3'b000;
   localparam logic [2:0] WIDTH_16S = 3'b010;
   localparam logic [2:0] WIDTH_16U = 3'b110;
   localparam logic [2:0] WIDTH_8S  = 3'b001;
   localparam logic [2:0] WIDTH_8U  = 3'b101;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      ERROR = 2'd3
   } store_state_t;

   typedef enum logic [1:0] {
      SZ_WORD = 2'd0,
      SZ_HALF = 2'd1,
      SZ_BYTE = 2'd2
   } store_size_t;

   // Bit 2 is the signedness flag and is irrelevant for stores; unused codes fall back to word.
   function automatic store_size_t width_size(input logic [2:0] width);
      case (width[1:0])
         2'b10:   return SZ_HALF;
         2'b01:   return SZ_BYTE;
         default: return SZ_WORD;
      endcase
   endfunction

   function automatic logic is_misaligned(input store_size_t size, input logic [1:0] offset);
      case (size)
         SZ_HALF: return offset[0];
         SZ_WORD: return offset != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational little-endian lane merge of right-aligned store data into an old memory word.
module store_lane_merge
   import store_rmw_pkg::*;
(
   input  logic [31:0] OldWord,
   input  logic [31:0] Data,
   input  logic [1:0]  ByteOffset,
   input  logic [2:0]  WidthSrc,
   output logic [31:0] MergedWord
);

   always_comb begin
      MergedWord = OldWord;
      case (width_size(WidthSrc))
         SZ_BYTE: MergedWord[{ByteOffset, 3'b000} +: 8]        = Data[7:0];
         SZ_HALF: MergedWord[{ByteOffset[1], 4'b0000} +: 16]   = Data[15:0];
         default: MergedWord = Data;
      endcase
   end

endmodule

// File: rtl/store_rmw.sv
// Store-side sub-word writer: word stores go straight to memory, byte/halfword stores
// read the target word, merge the lanes and write it back while stalling the pipeline.
module store_rmw
   import store_rmw_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         StoreReq,
   input  logic [31:0]  Addr,
   input  logic [31:0]  WriteData,
   input  logic [2:0]   WidthSrc,
   output logic         StoreAccept,
   output logic         StoreBusy,
   output logic         StoreDone,
   output logic         MisalignedErr,
   output logic [31:0]  MemAddr,
   output logic         MemReadEn,
   input  logic [31:0]  MemReadData,
   input  logic         MemReadValid,
   output logic         MemWriteEn,
   output logic [31:0]  MemWriteData,
   output store_state_t DbgState
);

   // Handshake: a store transfers in a cycle where StoreReq && StoreAccept; the requester
   // keeps StoreReq and its operands stable until then. MemReadData is consumed only in a
   // READ cycle with MemReadValid high; the read request stays up until that cycle.

   store_state_t r_state;
   store_state_t w_next_state;
   logic [31:0]  r_addr;
   logic [31:0]  r_data;
   logic [2:0]   r_width;
   logic [31:0]  r_merge;
   logic [31:0]  w_merged;
   logic         w_accept;
   store_size_t  w_req_size;
   store_size_t  w_cur_size;

   assign w_req_size = width_size(WidthSrc);
   assign w_cur_size = width_size(r_width);

   store_lane_merge u_merge (
      .OldWord    (MemReadData),
      .Data       (r_data),
      .ByteOffset (r_addr[1:0]),
      .WidthSrc   (r_width),
      .MergedWord (w_merged)
   );

   always_ff @(posedge clk) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state  = r_state;
      w_accept      = 1'b0;
      StoreBusy     = 1'b0;
      StoreDone     = 1'b0;
      MisalignedErr = 1'b0;
      MemReadEn     = 1'b0;
      MemWriteEn    = 1'b0;
      MemWriteData  = 32'h0;
      case (r_state)
         IDLE: begin
            w_accept = StoreReq;
            if (StoreReq) begin
               if (is_misaligned(w_req_size, Addr[1:0])) w_next_state = ERROR;
               else if (w_req_size == SZ_WORD)           w_next_state = WRITE;
               else                                      w_next_state = READ;
            end
         end
         READ: begin
            StoreBusy = 1'b1;
            MemReadEn = 1'b1;
            if (MemReadValid) w_next_state = WRITE;
         end
         WRITE: begin
            StoreBusy    = 1'b1;
            StoreDone    = 1'b1;
            MemWriteEn   = 1'b1;
            MemWriteData = (w_cur_size == SZ_WORD) ? r_data : r_merge;
            w_next_state = IDLE;
         end
         ERROR: begin
            StoreBusy     = 1'b1;
            MisalignedErr = 1'b1;
            w_next_state  = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_addr  <= 32'h0;
         r_data  <= 32'h0;
         r_width <= 3'b000;
         r_merge <= 32'h0;
      end else begin
         if (w_accept) begin
            r_addr  <= Addr;
            r_data  <= WriteData;
            r_width <= WidthSrc;
         end
         if (r_state == READ && MemReadValid) r_merge <= w_merged;
      end
   end

   assign StoreAccept = w_accept;
   assign MemAddr     = {r_addr[31:2], 2'b00};
   assign DbgState    = r_state;

endmodule

// File: tb/tb_store_rmw.sv
// Directed bench for store_rmw: reset, word/sub-word/misaligned stores, reset abort, back-to-back.
module tb_store_rmw;
   import store_rmw_pkg::*;

   logic         clk;
   logic         reset;
   logic         StoreReq;
   logic [31:0]  Addr;
   logic [31:0]  WriteData;
   logic [2:0]   WidthSrc;
   logic         StoreAccept;
   logic         StoreBusy;
   logic         StoreDone;
   logic         MisalignedErr;
   logic [31:0]  MemAddr;
   logic         MemReadEn;
   logic [31:0]  MemReadData;
   logic         MemReadValid;
   logic         MemWriteEn;
   logic [31:0]  MemWriteData;
   store_state_t DbgState;

   int errors = 0;
   int checks = 0;

   store_rmw dut (
      .clk           (clk),
      .reset         (reset),
      .StoreReq      (StoreReq),
      .Addr          (Addr),
      .WriteData     (WriteData),
      .WidthSrc      (WidthSrc),
      .StoreAccept   (StoreAccept),
      .StoreBusy     (StoreBusy),
      .StoreDone     (StoreDone),
      .MisalignedErr (MisalignedErr),
      .MemAddr       (MemAddr),
      .MemReadEn     (MemReadEn),
      .MemReadData   (MemReadData),
      .MemReadValid  (MemReadValid),
      .MemWriteEn    (MemWriteEn),
      .MemWriteData  (MemWriteData),
      .DbgState      (DbgState)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Read and write strobes must never overlap.
   always @(negedge clk) begin
      if (reset) begin
         checks++;
         if (MemReadEn && MemWriteEn) begin
            errors++;
            $display("FAIL rd_wr_overlap: MemReadEn=%0b MemWriteEn=%0b required not both 1", MemReadEn, MemWriteEn);
         end
      end
   end

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      StoreReq     = 1'b0;
      Addr         = 32'h0;
      WriteData    = 32'h0;
      WidthSrc     = WIDTH_32;
      MemReadData  = 32'h0;
      MemReadValid = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] outs;
      idle_inputs();
      reset = 1'b0;
      tick();
      tick();
      #1;
      outs = {StoreAccept, StoreBusy, StoreDone, MisalignedErr, MemReadEn, MemWriteEn, 26'h0};
      checks++;
      if (outs !== 32'h0) begin
         errors++;
         $display("FAIL reset_flags: got %h required 00000000", outs);
      end
      checks++;
      if (MemAddr !== 32'h0 || MemWriteData !== 32'h0) begin
         errors++;
         $display("FAIL reset_buses: MemAddr=%h MemWriteData=%h required 0/0", MemAddr, MemWriteData);
      end
      checks++;
      if (DbgState !== IDLE) begin
         errors++;
         $display("FAIL reset_state: got %0d required %0d", DbgState, IDLE);
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_word_store();
      StoreReq = 1'b1; Addr = 32'h100; WriteData = 32'hDEADBEEF; WidthSrc = WIDTH_32;
      #1;
      checks++;
      if (StoreAccept !== 1'b1) begin
         errors++;
         $display("FAIL word_accept: got %b required 1", StoreAccept);
      end
      tick();
      idle_inputs();
      #1;
      checks++;
      if (MemWriteEn !== 1'b1 || StoreDone !== 1'b1 || MemReadEn !== 1'b0 || StoreBusy !== 1'b1) begin
         errors++;
         $display("FAIL word_strobes: we=%b done=%b re=%b busy=%b required 1 1 0 1",
                  MemWriteEn, StoreDone, MemReadEn, StoreBusy);
      end
      checks++;
      if (MemAddr !== 32'h100 || MemWriteData !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL word_write: addr=%h data=%h required 00000100 deadbeef", MemAddr, MemWriteData);
      end
      tick();
      checks++;
      if (StoreBusy !== 1'b0 || MemWriteEn !== 1'b0 || StoreDone !== 1'b0) begin
         errors++;
         $display("FAIL word_idle: busy=%b we=%b done=%b required 0 0 0", StoreBusy, MemWriteEn, StoreDone);
      end
   endtask

   task automatic test_byte_store();
      StoreReq = 1'b1; Addr = 32'h203; WriteData = 32'h000000AB; WidthSrc = WIDTH_8U;
      #1;
      checks++;
      if (StoreAccept !== 1'b1) begin
         errors++;
         $display("FAIL byte_accept: got %b required 1", StoreAccept);
      end
      tick();
      idle_inputs();
      #1;
      checks++;
      if (MemReadEn !== 1'b1 || MemAddr !== 32'h200 || MemWriteEn !== 1'b0) begin
         errors++;
         $display("FAIL byte_read1: re=%b addr=%h we=%b required 1 00000200 0", MemReadEn, MemAddr, MemWriteEn);
      end
      tick();
      MemReadData = 32'h11223344; MemReadValid = 1'b1;
      #1;
      checks++;
      if (MemReadEn !== 1'b1 || StoreDone !== 1'b0) begin
         errors++;
         $display("FAIL byte_read2: re=%b done=%b required 1 0", MemReadEn, StoreDone);
      end
      tick();
      idle_inputs();
      #1;
      checks++;
      if (StoreDone !== 1'b1 || MemWriteEn !== 1'b1 || MemReadEn !== 1'b0 || MemWriteData !== 32'hAB223344) begin
         errors++;
         $display("FAIL byte_write: done=%b we=%b re=%b data=%h required 1 1 0 ab223344",
                  StoreDone, MemWriteEn, MemReadEn, MemWriteData);
      end
      tick();
      checks++;
      if (StoreBusy !== 1'b0) begin
         errors++;
         $display("FAIL byte_idle: busy=%b required 0", StoreBusy);
      end
   endtask

   task automatic test_half_store();
      StoreReq = 1'b1; Addr = 32'h302; WriteData = 32'hFFFFCAFE; WidthSrc = WIDTH_16S;
      tick();
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         if (i == 2) begin
            MemReadData = 32'h11223344; MemReadValid = 1'b1;
         end
         #1;
         checks++;
         if (MemReadEn !== 1'b1 || MemAddr !== 32'h300 || MemWriteEn !== 1'b0) begin
            errors++;
            $display("FAIL half_read_c%0d: re=%b addr=%h we=%b required 1 00000300 0",
                     i, MemReadEn, MemAddr, MemWriteEn);
         end
         tick();
      end
      idle_inputs();
      #1;
      checks++;
      if (MemWriteEn !== 1'b1 || MemWriteData !== 32'hCAFE3344) begin
         errors++;
         $display("FAIL half_write: we=%b data=%h required 1 cafe3344", MemWriteEn, MemWriteData);
      end
      tick();
   endtask

   // Single-cycle memory (valid in the first READ cycle), one vector per lane/width.
   task automatic test_lanes();
      logic [31:0] addr_t [6]  = '{32'h500, 32'h501, 32'h502, 32'h503, 32'h504, 32'h506};
      logic [31:0] data_t [6]  = '{32'hFFFFFF5A, 32'h5A, 32'h5A, 32'h5A, 32'h1234BEEF, 32'hBEEF};
      logic [2:0]  width_t [6] = '{WIDTH_8S, WIDTH_8S, WIDTH_8U, WIDTH_8S, WIDTH_16U, WIDTH_16S};
      logic [31:0] exp_t [6]   = '{32'h1122335A, 32'h11225A44, 32'h115A3344, 32'h5A223344,
                                   32'h1122BEEF, 32'hBEEF3344};
      for (int i = 0; i < 6; i++) begin
         StoreReq = 1'b1; Addr = addr_t[i]; WriteData = data_t[i]; WidthSrc = width_t[i];
         tick();
         idle_inputs();
         MemReadData = 32'h11223344; MemReadValid = 1'b1;
         tick();
         idle_inputs();
         #1;
         checks++;
         if (MemWriteEn !== 1'b1 || MemWriteData !== exp_t[i] || MemAddr !== {addr_t[i][31:2], 2'b00}) begin
            errors++;
            $display("FAIL lane_%0d: we=%b addr=%h data=%h required 1 %h %h",
                     i, MemWriteEn, MemAddr, MemWriteData, {addr_t[i][31:2], 2'b00}, exp_t[i]);
         end
         tick();
      end
   endtask

   task automatic test_misaligned();
      logic [31:0] addr_t [3]  = '{32'h401, 32'h102, 32'h203};
      logic [2:0]  width_t [3] = '{WIDTH_16U, WIDTH_32, WIDTH_16S};
      for (int i = 0; i < 3; i++) begin
         StoreReq = 1'b1; Addr = addr_t[i]; WriteData = 32'h55AA55AA; WidthSrc = width_t[i];
         tick();
         idle_inputs();
         #1;
         checks++;
         if (MisalignedErr !== 1'b1 || MemWriteEn !== 1'b0 || MemReadEn !== 1'b0 || StoreBusy !== 1'b1) begin
            errors++;
            $display("FAIL misaligned_%0d: err=%b we=%b re=%b busy=%b required 1 0 0 1",
                     i, MisalignedErr, MemWriteEn, MemReadEn, StoreBusy);
         end
         tick();
         checks++;
         if (MisalignedErr !== 1'b0 || StoreBusy !== 1'b0 || MemWriteEn !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_idle_%0d: err=%b busy=%b we=%b required 0 0 0",
                     i, MisalignedErr, StoreBusy, MemWriteEn);
         end
      end
   endtask

   task automatic test_unused_width();
      StoreReq = 1'b1; Addr = 32'h800; WriteData = 32'hA5A5F00D; WidthSrc = 3'b111;
      tick();
      idle_inputs();
      #1;
      checks++;
      if (MemWriteEn !== 1'b1 || MemReadEn !== 1'b0 || MemWriteData !== 32'hA5A5F00D) begin
         errors++;
         $display("FAIL unused_width: we=%b re=%b data=%h required 1 0 a5a5f00d", MemWriteEn, MemReadEn, MemWriteData);
      end
      tick();
   endtask

   task automatic test_reset_mid_store();
      StoreReq = 1'b1; Addr = 32'h203; WriteData = 32'hAB; WidthSrc = WIDTH_8U;
      tick();
      idle_inputs();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      MemReadData = 32'h11223344; MemReadValid = 1'b1;
      #1;
      checks++;
      if (DbgState !== IDLE || StoreBusy !== 1'b0 || MemReadEn !== 1'b0 || MemWriteEn !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_state: state=%0d busy=%b re=%b we=%b required 0 0 0 0",
                  DbgState, StoreBusy, MemReadEn, MemWriteEn);
      end
      checks++;
      if (MemAddr !== 32'h0 || MemWriteData !== 32'h0 || StoreDone !== 1'b0 || MisalignedErr !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_outs: addr=%h data=%h done=%b err=%b required 0 0 0 0",
                  MemAddr, MemWriteData, StoreDone, MisalignedErr);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         MemReadValid = 1'b0;
         #1;
         checks++;
         if (MemWriteEn !== 1'b0 || StoreBusy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_after_%0d: we=%b busy=%b required 0 0", i, MemWriteEn, StoreBusy);
         end
      end
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      StoreReq = 1'b1; Addr = 32'h603; WriteData = 32'h77; WidthSrc = WIDTH_8U;
      tick();
      // Second request presented and held while the first is in flight.
      Addr = 32'h700; WriteData = 32'h12345678; WidthSrc = WIDTH_32;
      MemReadData = 32'hAABBCCDD; MemReadValid = 1'b1;
      #1;
      checks++;
      if (StoreAccept !== 1'b0 || MemReadEn !== 1'b1) begin
         errors++;
         $display("FAIL b2b_busy_read: accept=%b re=%b required 0 1", StoreAccept, MemReadEn);
      end
      tick();
      MemReadData = 32'h0; MemReadValid = 1'b0;
      #1;
      checks++;
      if (StoreAccept !== 1'b0 || MemWriteEn !== 1'b1 || MemAddr !== 32'h600 || MemWriteData !== 32'h77BBCCDD) begin
         errors++;
         $display("FAIL b2b_first_write: accept=%b we=%b addr=%h data=%h required 0 1 00000600 77bbccdd",
                  StoreAccept, MemWriteEn, MemAddr, MemWriteData);
      end
      tick();
      #1;
      checks++;
      if (StoreAccept !== 1'b1 || StoreBusy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_second_accept: accept=%b busy=%b required 1 0", StoreAccept, StoreBusy);
      end
      tick();
      idle_inputs();
      #1;
      checks++;
      if (MemWriteEn !== 1'b1 || MemAddr !== 32'h700 || MemWriteData !== 32'h12345678) begin
         errors++;
         $display("FAIL b2b_second_write: we=%b addr=%h data=%h required 1 00000700 12345678",
                  MemWriteEn, MemAddr, MemWriteData);
      end
      tick();
      checks++;
      if (StoreBusy !== 1'b0 || MemWriteEn !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle: busy=%b we=%b required 0 0", StoreBusy, MemWriteEn);
      end
   endtask

   initial begin
      reset = 1'b0;
      idle_inputs();
      test_reset();
      test_word_store();
      test_byte_store();
      test_half_store();
      test_lanes();
      test_misaligned();
      test_unused_width();
      test_reset_mid_store();
      test_back_to_back();
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
